// File: rtl/ps2_key_controller_if.sv
// PS/2 key controller bus: byte stream in, game commands out.
// The master side is the byte receiver / game core, slave is the controller.
interface ps2_key_controller_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_err;
   logic       paddle_left;
   logic       paddle_right;
   logic       pause;
   logic       game_start;
   logic [3:0] level;
   logic       level_load;
   logic [7:0] err_count;
   logic       busy;

   modport master (
      output rx_valid, rx_byte, rx_err,
      input  paddle_left, paddle_right, pause, game_start,
      input  level, level_load, err_count, busy
   );

   modport slave (
      input  rx_valid, rx_byte, rx_err,
      output paddle_left, paddle_right, pause, game_start,
      output level, level_load, err_count, busy
   );
endinterface

// File: rtl/ps2_key_controller.sv
// Scan-code-set-2 sequencer turning PS/2 bytes into Breakout commands.
// Handles E0/F0 prefixes, inter-byte timeout and error counting.
module ps2_key_controller #(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int DEFAULT_LEVEL  = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   ps2_key_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TERM    = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    LVL_RST = 4'(DEFAULT_LEVEL);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          arw_l_q, arw_l_d;
   logic          key_a_q, key_a_d;
   logic          arw_r_q, arw_r_d;
   logic          key_d_q, key_d_d;
   logic          last_r_q, last_r_d;
   logic          p_held_q, p_held_d;
   logic          sp_held_q, sp_held_d;
   logic          pause_q, pause_d;
   logic          start_q, start_d;
   logic          load_q, load_d;
   logic [3:0]    level_q, level_d;
   logic [7:0]    errc_q, errc_d;

   logic          dec, brk, ext, timeout;
   logic          hit_al, hit_a, hit_ar, hit_d, hit_p, hit_sp;
   logic [3:0]    dig;
   logic          left_held, right_held;

   // Digit scan code to level; zero means not a digit key.
   function automatic logic [3:0] lvl_map(input logic [7:0] b);
      logic [3:0] r;
      case (b)
         8'h16:   r = 4'd1;
         8'h1E:   r = 4'd2;
         8'h26:   r = 4'd3;
         8'h25:   r = 4'd4;
         8'h2E:   r = 4'd5;
         8'h36:   r = 4'd6;
         8'h3D:   r = 4'd7;
         8'h3E:   r = 4'd8;
         default: r = 4'd0;
      endcase
      return r;
   endfunction

   // Prefix FSM next state plus decode of the completed key event.
   always_comb begin
      state_d = state_q;
      dec     = 1'b0;
      brk     = 1'b0;
      ext     = 1'b0;
      timeout = (state_q != IDLE) && !bus.rx_valid && (cnt_q == TERM);
      if (bus.rx_valid && bus.rx_err) begin
         state_d = IDLE;
      end else if (bus.rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (bus.rx_byte == 8'hE0)      state_d = EXT;
               else if (bus.rx_byte == 8'hF0) state_d = BRK;
               else                           dec = 1'b1;
            end
            EXT: begin
               if (bus.rx_byte == 8'hF0) begin
                  state_d = EXT_BRK;
               end else begin
                  dec     = 1'b1;
                  ext     = 1'b1;
                  state_d = IDLE;
               end
            end
            BRK: begin
               dec     = 1'b1;
               brk     = 1'b1;
               state_d = IDLE;
            end
            EXT_BRK: begin
               dec     = 1'b1;
               brk     = 1'b1;
               ext     = 1'b1;
               state_d = IDLE;
            end
         endcase
      end else if (timeout) begin
         state_d = IDLE;
      end
   end

   // Key hits and the next value of every held flag and output register.
   always_comb begin
      hit_al    = dec &  ext & (bus.rx_byte == 8'h6B);
      hit_ar    = dec &  ext & (bus.rx_byte == 8'h74);
      hit_a     = dec & ~ext & (bus.rx_byte == 8'h1C);
      hit_d     = dec & ~ext & (bus.rx_byte == 8'h23);
      hit_p     = dec & ~ext & (bus.rx_byte == 8'h4D);
      hit_sp    = dec & ~ext & (bus.rx_byte == 8'h29);
      dig       = (dec & ~ext) ? lvl_map(bus.rx_byte) : 4'd0;

      cnt_d     = cnt_q;
      arw_l_d   = arw_l_q;
      key_a_d   = key_a_q;
      arw_r_d   = arw_r_q;
      key_d_d   = key_d_q;
      last_r_d  = last_r_q;
      p_held_d  = p_held_q;
      sp_held_d = sp_held_q;
      pause_d   = pause_q;
      start_d   = 1'b0;
      load_d    = 1'b0;
      level_d   = level_q;
      errc_d    = errc_q;

      if (bus.rx_valid || state_q == IDLE || timeout) cnt_d = '0;
      else                                          cnt_d = cnt_q + CW'(1);

      if (hit_al) arw_l_d = ~brk;
      if (hit_a)  key_a_d = ~brk;
      if (hit_ar) arw_r_d = ~brk;
      if (hit_d)  key_d_d = ~brk;
      if ((hit_al | hit_a) & ~brk) last_r_d = 1'b0;
      if ((hit_ar | hit_d) & ~brk) last_r_d = 1'b1;

      if (hit_p) begin
         if (~brk & ~p_held_q) pause_d = ~pause_q;
         p_held_d = ~brk;
      end

      if (hit_sp) begin
         start_d   = ~brk & ~sp_held_q;
         sp_held_d = ~brk;
      end

      if (brk && dig != 4'd0) begin
         level_d = dig;
         load_d  = 1'b1;
      end

      if (((bus.rx_valid & bus.rx_err) | timeout) && errc_q != 8'hFF)
         errc_d = errc_q + 8'd1;
   end

   // State register for the prefix FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Held flags, pulses, level, error count and timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         arw_l_q   <= 1'b0;
         key_a_q   <= 1'b0;
         arw_r_q   <= 1'b0;
         key_d_q   <= 1'b0;
         last_r_q  <= 1'b0;
         p_held_q  <= 1'b0;
         sp_held_q <= 1'b0;
         pause_q   <= 1'b0;
         start_q   <= 1'b0;
         load_q    <= 1'b0;
         level_q   <= LVL_RST;
         errc_q    <= 8'd0;
      end else begin
         cnt_q     <= cnt_d;
         arw_l_q   <= arw_l_d;
         key_a_q   <= key_a_d;
         arw_r_q   <= arw_r_d;
         key_d_q   <= key_d_d;
         last_r_q  <= last_r_d;
         p_held_q  <= p_held_d;
         sp_held_q <= sp_held_d;
         pause_q   <= pause_d;
         start_q   <= start_d;
         load_q    <= load_d;
         level_q   <= level_d;
         errc_q    <= errc_d;
      end
   end

   // Newest direction wins when both sides are held.
   assign left_held  = arw_l_q | key_a_q;
   assign right_held = arw_r_q | key_d_q;

   assign bus.paddle_left  = left_held  & (~right_held | ~last_r_q);
   assign bus.paddle_right = right_held & (~left_held  |  last_r_q);
   assign bus.pause        = pause_q;
   assign bus.game_start   = start_q;
   assign bus.level        = level_q;
   assign bus.level_load   = load_q;
   assign bus.err_count    = errc_q;
   assign bus.busy         = (state_q != IDLE);

endmodule
